// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1 -- 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined).
//
// Oversamples the asynchronous rx line with clk, validates the start bit at
// mid-bit and samples data, optional parity and stop bits at bit centres.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : one even-parity bit follows data bit 7; a bad parity with a
//               good stop bit gives a parity_err pulse instead of rxvalid.
//   undefined : plain 8N1, parity_err is tied low.
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per serial bit (even, >= 4).
//
// Ports:
//   clk         in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   rx          in   serial line, idle high, asynchronous to clk
//   rxbyte      out  last correctly received byte (first wire bit in bit 0)
//   rxvalid     out  one-cycle strobe, rxbyte updated in the same cycle
//   framing_err out  one-cycle strobe, stop bit sampled low
//   parity_err  out  one-cycle strobe, parity mismatch (parity build only)
//   busy        out  high whenever the receiver is not idle
`timescale 1ns/1ps

module uart_rx_8n1 #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rx,
   output logic [7:0] rxbyte,
   output logic       rxvalid,
   output logic       framing_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
`ifdef UART_RX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   state_t           state_q, state_d;
   logic             rx_meta_q, rx_s_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [7:0]       rxbyte_q, rxbyte_d;
   logic             rxvalid_q, rxvalid_d;
   logic             framing_err_q, framing_err_d;
`ifdef UART_RX_PARITY_EN
   logic             parity_err_q, parity_err_d;
   logic             par_bad_q, par_bad_d;
`endif

   // Two-flop synchroniser; reset to the idle (high) line level so reset
   // release never looks like a start bit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         shreg_q       <= '0;
         rxbyte_q      <= '0;
         rxvalid_q     <= 1'b0;
         framing_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q  <= 1'b0;
         par_bad_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         shreg_q       <= shreg_d;
         rxbyte_q      <= rxbyte_d;
         rxvalid_q     <= rxvalid_d;
         framing_err_q <= framing_err_d;
`ifdef UART_RX_PARITY_EN
         parity_err_q  <= parity_err_d;
         par_bad_q     <= par_bad_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q + CNT_W'(1);
      bit_idx_d     = bit_idx_q;
      shreg_d       = shreg_q;
      rxbyte_d      = rxbyte_q;
      rxvalid_d     = 1'b0;
      framing_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d  = 1'b0;
      par_bad_d     = par_bad_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end

         // Re-check the line half a bit later; a high level here was a glitch.
         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  state_d   = S_DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         // Sample point now sits at bit centres; the counter is also cleared
         // here so non-power-of-two CLKS_PER_BIT values wrap correctly.
         S_DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d     = '0;
               shreg_d   = {rx_s_q, shreg_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         // Even parity: data bits XOR parity bit must be 0.
         S_PARITY: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d     = '0;
               par_bad_d = ^{shreg_q, rx_s_q};
               state_d   = S_STOP;
            end
         end
`endif

         S_STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_bad_q) begin
                     parity_err_d = 1'b1;
                  end else begin
                     rxbyte_d  = shreg_q;
                     rxvalid_d = 1'b1;
                  end
`else
                  rxbyte_d  = shreg_q;
                  rxvalid_d = 1'b1;
`endif
               end else begin
                  framing_err_d = 1'b1;
                  state_d       = S_BREAK;
               end
            end
         end

         // Wait out a held-low line so a break yields a single framing error.
         S_BREAK: begin
            if (rx_s_q) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign rxbyte      = rxbyte_q;
   assign rxvalid     = rxvalid_q;
   assign framing_err = framing_err_q;
   assign busy        = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err  = parity_err_q;
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1 -- directed self-checking bench for uart_rx_8n1.
// Frames are driven on the falling clock edge; outputs are sampled on the
// falling edge. Build with UART_RX_PARITY_EN to add the even-parity scenario.
`timescale 1ns/1ps

module tb_uart_rx_8n1;

   localparam int unsigned CPB = 16;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rxbyte;
   logic       rxvalid;
   logic       framing_err;
   logic       parity_err;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;
   int perr_cnt = 0;
   logic [7:0] byte_log [0:63];

   uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .rx          (rx),
      .rxbyte      (rxbyte),
      .rxvalid     (rxvalid),
      .framing_err (framing_err),
      .parity_err  (parity_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Strobe monitor: counts every pulse cycle; a stretched pulse would count twice.
   always @(negedge clk) begin
      if (resetn) begin
         if (rxvalid) begin
            if (valid_cnt < 64) byte_log[valid_cnt] = rxbyte;
            valid_cnt++;
         end
         if (framing_err) ferr_cnt++;
         if (parity_err) perr_cnt++;
         if (int'(rxvalid) + int'(framing_err) + int'(parity_err) > 1) begin
            errors++;
            $display("FAIL strobe_exclusive: valid=%0b ferr=%0b perr=%0b, required at most one high",
                     rxvalid, framing_err, parity_err);
         end
      end
   end

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   // Leaves rx at the stop level; callers drive idle or the next frame.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(^d);
`endif
      drive_bit(stop);
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (rxbyte !== 8'h00) begin errors++; $display("FAIL reset_rxbyte: got %0h expected 00", rxbyte); end
      checks++; if (rxvalid !== 1'b0) begin errors++; $display("FAIL reset_rxvalid: got %0b expected 0", rxvalid); end
      checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %0b expected 0", framing_err); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %0b expected 0", parity_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      resetn = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single_byte;
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      send_frame(8'h55, 1'b1);
      drive_bit(1'b1);
      checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL single_valid_count: got %0d expected 1", valid_cnt - v0); end
      checks++; if (byte_log[v0] !== 8'h55) begin errors++; $display("FAIL single_strobe_byte: got %0h expected 55", byte_log[v0]); end
      checks++; if (rxbyte !== 8'h55) begin errors++; $display("FAIL single_rxbyte: got %0h expected 55", rxbyte); end
      checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL single_ferr: got %0d expected 0", ferr_cnt - f0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %0b expected 0", busy); end
   endtask

   task automatic test_back_to_back;
      int v0 = valid_cnt;
      send_frame(8'hA5, 1'b1);
      send_frame(8'h3C, 1'b1);
      drive_bit(1'b1);
      checks++; if (valid_cnt - v0 != 2) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 2", valid_cnt - v0); end
      checks++; if (byte_log[v0] !== 8'hA5) begin errors++; $display("FAIL b2b_first: got %0h expected a5", byte_log[v0]); end
      checks++; if (byte_log[v0+1] !== 8'h3C) begin errors++; $display("FAIL b2b_second: got %0h expected 3c", byte_log[v0+1]); end
   endtask

   task automatic test_glitch;
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      int cycles = 0;
      logic seen = 1'b0;
      rx = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      rx = 1'b1;
      while (busy && cycles < int'(CPB / 2 + 3)) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
         cycles++;
      end
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse: got %0b expected 1", seen); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_return: got %0b expected 0 after %0d cycles", busy, cycles); end
      drive_bit(1'b1);
      checks++; if (valid_cnt != v0) begin errors++; $display("FAIL glitch_no_valid: got %0d expected 0", valid_cnt - v0); end
      checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL glitch_no_ferr: got %0d expected 0", ferr_cnt - f0); end
   endtask

   task automatic test_break;
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      int p0 = perr_cnt;
      send_frame(8'hFF, 1'b0);
      repeat (40 * CPB) @(negedge clk);
      drive_bit(1'b1);
      drive_bit(1'b1);
      checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL break_ferr_count: got %0d expected 1", ferr_cnt - f0); end
      checks++; if (valid_cnt != v0) begin errors++; $display("FAIL break_no_valid: got %0d expected 0", valid_cnt - v0); end
      checks++; if (perr_cnt != p0) begin errors++; $display("FAIL break_no_perr: got %0d expected 0", perr_cnt - p0); end
      checks++; if (rxbyte !== 8'h3C) begin errors++; $display("FAIL break_rxbyte_kept: got %0h expected 3c", rxbyte); end
      v0 = valid_cnt;
      send_frame(8'h12, 1'b1);
      drive_bit(1'b1);
      checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL after_break_valid: got %0d expected 1", valid_cnt - v0); end
      checks++; if (rxbyte !== 8'h12) begin errors++; $display("FAIL after_break_rxbyte: got %0h expected 12", rxbyte); end
   endtask

   task automatic test_reset_midframe;
      int v0;
      logic [7:0] d;
      d = 8'h81;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      rx = d[4];
      repeat (CPB / 2) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %0b expected 1", busy); end
      #2 resetn = 1'b0;
      #1;
      checks++; if (rxbyte !== 8'h00) begin errors++; $display("FAIL midreset_rxbyte: got %0h expected 00", rxbyte); end
      checks++; if (rxvalid !== 1'b0) begin errors++; $display("FAIL midreset_rxvalid: got %0b expected 0", rxvalid); end
      checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL midreset_ferr: got %0b expected 0", framing_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %0b expected 0", busy); end
      rx = 1'b1;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      drive_bit(1'b1);
      v0 = valid_cnt;
      send_frame(8'h7E, 1'b1);
      drive_bit(1'b1);
      checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL post_reset_valid: got %0d expected 1", valid_cnt - v0); end
      checks++; if (rxbyte !== 8'h7E) begin errors++; $display("FAIL post_reset_rxbyte: got %0h expected 7e", rxbyte); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_frame_par(input logic [7:0] d, input logic par, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(par);
      drive_bit(stop);
   endtask

   task automatic test_parity;
      int v0 = valid_cnt;
      int p0 = perr_cnt;
      send_frame_par(8'h03, 1'b0, 1'b1);
      drive_bit(1'b1);
      checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL parity_good_valid: got %0d expected 1", valid_cnt - v0); end
      checks++; if (rxbyte !== 8'h03) begin errors++; $display("FAIL parity_good_rxbyte: got %0h expected 03", rxbyte); end
      checks++; if (perr_cnt != p0) begin errors++; $display("FAIL parity_good_perr: got %0d expected 0", perr_cnt - p0); end
      v0 = valid_cnt;
      send_frame_par(8'h03, 1'b1, 1'b1);
      drive_bit(1'b1);
      checks++; if (perr_cnt - p0 != 1) begin errors++; $display("FAIL parity_bad_perr: got %0d expected 1", perr_cnt - p0); end
      checks++; if (valid_cnt != v0) begin errors++; $display("FAIL parity_bad_no_valid: got %0d expected 0", valid_cnt - v0); end
      checks++; if (rxbyte !== 8'h03) begin errors++; $display("FAIL parity_bad_rxbyte: got %0h expected 03", rxbyte); end
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_glitch();
      test_break();
      test_reset_midframe();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
